// File: rtl/enemy_pkg.sv
//------------------------------------------------------------------------------
// enemy_pkg : shared types and constants for the whack-a-mole enemy spawner.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package enemy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int NUM_HOLES  = 9;
  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_IDX_W = $clog2(NUM_SLOTS);
  localparam int HOLE_W     = 4;
  localparam int POS_W      = 5;
  localparam int LIFE_W     = 8;
  localparam int GAP_W      = 8;
  localparam int SCORE_W    = 8;
  localparam int MISS_W     = 3;
  localparam int LFSR_W     = 16;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [NUM_SLOTS-1:0][POS_W-1:0] SLOT_OFFSET = {5'd20, 5'd11, 5'd0, 5'd0};

  function automatic logic [HOLE_W-1:0] lfsr_to_hole(input logic [3:0] nib);
    return (nib % 4'd9) + 4'd1;
  endfunction

  function automatic logic [LIFE_W-1:0] speedup_life(input logic [LIFE_W-1:0]  base,
                                                     input logic [SCORE_W-1:0] score);
    logic [LIFE_W:0] floor_sum;
    floor_sum = {1'b0, (score >> 3)} + 9'd4;
    if (floor_sum <= {1'b0, base}) return base - (score >> 3);
    else return 8'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_spawner_lfsr16.sv
//------------------------------------------------------------------------------
// lfsr16 : 16-bit Galois LFSR, advances one step per enabled cycle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lfsr16
  import enemy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= seed_i;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/enemy_spawner.sv
//------------------------------------------------------------------------------
// enemy_spawner : spawns enemies into four slots, scores strikes, counts misses.
// Optional ENEMY_SPEEDUP_EN shortens new-enemy lifetime as the score grows.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enemy_spawner
  import enemy_pkg::*;
#(
  parameter int          LIFETIME  = 20,
  parameter int          SPAWN_GAP = 6,
  parameter int          MAX_MISS  = 5,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               key_valid,
  input  logic [HOLE_W-1:0]  key_hole,
  output logic [POS_W-1:0]   pos_0,
  output logic [POS_W-1:0]   pos_1,
  output logic [POS_W-1:0]   pos_2,
  output logic [POS_W-1:0]   pos_3,
  output logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  miss_cnt,
  output logic               game_over
);

  localparam logic [LIFE_W-1:0] LIFE_INIT  = LIFE_W'(LIFETIME);
  localparam logic [GAP_W-1:0]  GAP_INIT   = GAP_W'(SPAWN_GAP);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);

  state_e                               state_q, state_d;
  logic [NUM_SLOTS-1:0]                 active_q, active_d;
  logic [NUM_SLOTS-1:0][HOLE_W-1:0]     hole_q, hole_d;
  logic [NUM_SLOTS-1:0][LIFE_W-1:0]     life_q, life_d;
  logic [NUM_SLOTS-1:0][POS_W-1:0]      pos_q, pos_d;
  logic [GAP_W-1:0]                     gap_q, gap_d;
  logic [SCORE_W-1:0]                   score_q, score_d;
  logic [MISS_W-1:0]                    miss_q, miss_d;
  logic                                 hit_q, hit_d;
  logic                                 over_q, over_d;

  logic [LFSR_W-1:0]    w_lfsr;
  logic                 w_lfsr_unused;
  logic [HOLE_W-1:0]    w_new_hole;
  logic [LIFE_W-1:0]    w_new_life;
  logic                 w_key_ok;
  logic [NUM_SLOTS-1:0] w_struck, w_expire, w_dup;
  logic                 w_free, w_spawn;
  logic [SLOT_IDX_W-1:0] w_free_idx;
  logic [MISS_W-1:0]    w_n_exp;
  logic [MISS_W:0]      w_miss_sum;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (tick && (state_q == ST_PLAY)),
    .seed_i  (SEED),
    .state_o (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:4];
  assign w_new_hole    = lfsr_to_hole(w_lfsr[3:0]);
  assign w_key_ok      = key_valid && (key_hole >= 4'd1) && (key_hole <= 4'(NUM_HOLES));

`ifdef ENEMY_SPEEDUP_EN
  assign w_new_life = speedup_life(LIFE_INIT, score_q);
`else
  assign w_new_life = LIFE_INIT;
`endif

  // Per-slot events evaluated on the current (pre-update) slot contents, so a
  // slot freed this cycle is never offered to the spawner until the next tick.
  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    w_n_exp    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_struck[i] = w_key_ok && active_q[i] && (hole_q[i] == key_hole);
      w_expire[i] = tick && active_q[i] && !w_struck[i] && (life_q[i] == LIFE_W'(1));
      w_dup[i]    = active_q[i] && (hole_q[i] == w_new_hole);
      if (!active_q[i]) begin
        w_free     = 1'b1;
        w_free_idx = SLOT_IDX_W'(i);
      end
      w_n_exp = w_n_exp + MISS_W'(w_expire[i]);
    end
  end

  assign w_spawn    = tick && (gap_q == '0) && w_free && !(|w_dup);
  assign w_miss_sum = {1'b0, miss_q} + {1'b0, w_n_exp};

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    hole_d   = hole_q;
    life_d   = life_q;
    gap_d    = gap_q;
    score_d  = score_q;
    miss_d   = miss_q;
    hit_d    = 1'b0;

    unique case (state_q)
      ST_PLAY: begin
        if (miss_q >= MISS_LIMIT) begin
          state_d  = ST_OVER;
          active_d = '0;
          life_d   = '0;
        end else begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_struck[i]) begin
              active_d[i] = 1'b0;
              life_d[i]   = '0;
            end else if (tick && active_q[i]) begin
              life_d[i] = life_q[i] - LIFE_W'(1);
              if (w_expire[i]) active_d[i] = 1'b0;
            end
          end
          if (|w_struck) begin
            hit_d = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end
          miss_d = w_miss_sum[MISS_W] ? '1 : w_miss_sum[MISS_W-1:0];
          if (w_spawn) begin
            active_d[w_free_idx] = 1'b1;
            hole_d[w_free_idx]   = w_new_hole;
            life_d[w_free_idx]   = w_new_life;
            gap_d                = GAP_INIT;
          end else if (tick && (gap_q != '0)) begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_d  = ST_PLAY;
          active_d = '0;
          life_d   = '0;
          gap_d    = '0;
          score_d  = '0;
          miss_d   = '0;
        end
      end
    endcase

    for (int i = 0; i < NUM_SLOTS; i++)
      pos_d[i] = active_d[i] ? (POS_W'(hole_d[i]) + SLOT_OFFSET[i]) : '0;
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      hole_q   <= '0;
      life_q   <= '0;
      pos_q    <= '0;
      gap_q    <= '0;
      score_q  <= '0;
      miss_q   <= '0;
      hit_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      hole_q   <= hole_d;
      life_q   <= life_d;
      pos_q    <= pos_d;
      gap_q    <= gap_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      hit_q    <= hit_d;
      over_q   <= over_d;
    end
  end

  assign pos_0     = pos_q[0];
  assign pos_1     = pos_q[1];
  assign pos_2     = pos_q[2];
  assign pos_3     = pos_q[3];
  assign hit       = hit_q;
  assign score     = score_q;
  assign miss_cnt  = miss_q;
  assign game_over = over_q;

endmodule

`default_nettype wire
